// File: rtl/srm_pkg.sv
// Shared types and encoding constants for the SRM instruction-memory loader.
package srm_pkg;

  typedef enum logic [2:0] {
    MOV_IMM = 3'd0,
    MOV_REG = 3'd1,
    ADD     = 3'd2,
    CMP     = 3'd3,
    AND     = 3'd4,
    MVN     = 3'd5,
    LDR     = 3'd6,
    STR     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } sh_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_STR = 3'b100;

  localparam logic [1:0] MOV_SEL_IMM = 2'b10;
  localparam logic [1:0] MOV_SEL_REG = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_APPEND  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/srm_encoder.sv
// Combinational encoder: decoded instruction fields to a 16-bit SRM word.
module srm_encoder
  import srm_pkg::*;
(
  input  op_e         op,
  input  logic [2:0]  rd,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [1:0]  sh,
  input  logic [7:0]  imm,
  input  logic        halt,
  output logic [15:0] word,
  output logic        imm_err
);

  always_comb begin
    word    = HALT_WORD;
    imm_err = 1'b0;
    if (!halt) begin
      unique case (op)
        MOV_IMM: word = {OPC_MOV, MOV_SEL_IMM, rn, imm};
        MOV_REG: word = {OPC_MOV, MOV_SEL_REG, 3'b000, rd, sh, rm};
        ADD:     word = {OPC_ALU, ALU_ADD, rn, rd, sh, rm};
        CMP:     word = {OPC_ALU, ALU_CMP, rn, rd, sh, rm};
        AND:     word = {OPC_ALU, ALU_AND, rn, rd, sh, rm};
        MVN:     word = {OPC_ALU, ALU_MVN, rn, rd, sh, rm};
        // imm5 is signed; upper imm8 bits must be its sign extension
        LDR: begin
          word    = {OPC_LDR, 2'b00, rn, rd, imm[4:0]};
          imm_err = (imm[7:5] != {3{imm[4]}});
        end
        STR: begin
          word    = {OPC_STR, 2'b00, rn, rd, imm[4:0]};
          imm_err = (imm[7:5] != {3{imm[4]}});
        end
      endcase
    end
  end

endmodule

// File: rtl/srm_program_loader.sv
// Streams encoded SRM instructions into instruction memory, holding the CPU
// in reset until the program (always HALT-terminated) is in place.
//
// state      | meaning
// ST_IDLE    | waiting for start; CPU reset output unchanged
// ST_LOAD    | accepting beats, one registered write per accepted beat
// ST_APPEND  | writing the trailing HALT the stream did not supply
// ST_RELEASE | releasing the CPU and pulsing done on the next cycle
module srm_program_loader
  import srm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rn,
  input  logic [2:0]        in_rm,
  input  logic [1:0]        in_sh,
  input  logic [7:0]        in_imm,
  input  logic              in_halt,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       enc_word;
  logic              enc_err;
  logic              accept;
  logic              wr_en;
  logic [15:0]       wr_word;
  logic              wr_err;
  logic              latch_start;
  logic              rel_cpu;

  srm_encoder u_enc (
    .op      (op_e'(in_op)),
    .rd      (in_rd),
    .rn      (in_rn),
    .rm      (in_rm),
    .sh      (in_sh),
    .imm     (in_imm),
    .halt    (in_halt),
    .word    (enc_word),
    .imm_err (enc_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    if (accept && in_last) state_d = in_halt ? ST_RELEASE : ST_APPEND;
      ST_APPEND:  state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_LOAD);
    busy        = (state_q == ST_LOAD) || (state_q == ST_APPEND);
    accept      = in_ready && in_valid;
    latch_start = (state_q == ST_IDLE) && start;
    rel_cpu     = (state_q == ST_RELEASE);
    wr_en       = 1'b0;
    wr_word     = enc_word;
    wr_err      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        wr_en  = accept;
        wr_err = accept && enc_err;
      end
      ST_APPEND: begin
        wr_en   = 1'b1;
        wr_word = HALT_WORD;
      end
      default: ;
    endcase
  end

  // Write port, address counter and CPU handoff registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      start_pc  <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= wr_en;
      done   <= 1'b0;
      if (wr_en) begin
        mem_addr  <= addr_q;
        mem_wdata <= DATA_W'(wr_word);
        addr_q    <= addr_q + 1'b1;
        if (wr_err || (&addr_q)) err <= 1'b1;
      end
      if (latch_start) begin
        addr_q    <= base_addr;
        start_pc  <= base_addr;
        cpu_rst_n <= 1'b0;
        err       <= 1'b0;
      end
      if (rel_cpu) begin
        cpu_rst_n <= 1'b1;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_srm_program_loader.sv
// Self-checking bench for srm_program_loader against a queue-based program model.
module tb_srm_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op, in_rd, in_rn, in_rm;
  logic [1:0] in_sh;
  logic [7:0] in_imm;
  logic       in_halt, in_last;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata;
  logic       cpu_rst_n;
  logic [7:0] start_pc;
  logic       busy, done, err;

  always #5 clk = ~clk;

  srm_program_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_sh(in_sh),
    .in_imm(in_imm), .in_halt(in_halt), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .start_pc(start_pc), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct {
    int op; int rd; int rn; int rm; int sh; int imm; bit halt; bit last;
  } beat_t;

  beat_t beats[$];
  int    wa_q[$];
  int    wd_q[$];
  int    wt_q[$];
  int    total = 0;
  int    bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(int'(mem_wdata));
      wt_q.push_back(int'($time));
    end
  end

  function automatic beat_t mk(int op, int rd, int rn, int rm, int sh, int imm, bit halt, bit last);
    beat_t b;
    b.op = op; b.rd = rd; b.rn = rn; b.rm = rm; b.sh = sh; b.imm = imm;
    b.halt = halt; b.last = last;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255),
              ($urandom_range(0, 9) == 0), 1'b0);
  endfunction

  // Reference encoding built from field weights
  function automatic int enc(beat_t b);
    if (b.halt) return 'hE000;
    case (b.op)
      0:          return 'hD000 + b.rn * 256 + b.imm;
      1:          return 'hC000 + b.rd * 32 + b.sh * 8 + b.rm;
      2, 3, 4, 5: return 'hA000 + (b.op - 2) * 2048 + b.rn * 256 + b.rd * 32 + b.sh * 8 + b.rm;
      6:          return 'h6000 + b.rn * 256 + b.rd * 32 + (b.imm % 32);
      default:    return 'h8000 + b.rn * 256 + b.rd * 32 + (b.imm % 32);
    endcase
  endfunction

  function automatic bit imm_bad(beat_t b);
    int s;
    if (b.halt || b.op < 6) return 1'b0;
    s = (b.imm >= 128) ? b.imm - 256 : b.imm;
    return (s < -16) || (s > 15);
  endfunction

  task automatic drive_beat(beat_t b);
    in_op   = 3'(b.op);
    in_rd   = 3'(b.rd);
    in_rn   = 3'(b.rn);
    in_rm   = 3'(b.rm);
    in_sh   = 2'(b.sh);
    in_imm  = 8'(b.imm);
    in_halt = b.halt;
    in_last = b.last;
  endtask

  task automatic run_session(input int base, input bit gaps, input bit poke_start);
    int  exp_a[$];
    int  exp_d[$];
    bit  exp_err;
    bit  rdy, ok, last_halt;
    int  acc_t, tmo, n;
    n = beats.size();
    exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back((base + i) % 256);
      exp_d.push_back(enc(beats[i]));
      if (imm_bad(beats[i])) exp_err = 1'b1;
    end
    last_halt = beats[n-1].halt;
    if (!last_halt) begin
      exp_a.push_back((base + n) % 256);
      exp_d.push_back('hE000);
    end
    foreach (exp_a[i]) if (exp_a[i] == 255) exp_err = 1'b1;
    wa_q.delete(); wd_q.delete(); wt_q.delete();

    start = 1'b1;
    base_addr = 8'(base);
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 8'($urandom);
    @(negedge clk);
    chk_eq("start_ready", in_ready, 1'b1);
    chk_eq("start_busy", busy, 1'b1);
    chk_eq("start_cpu_rst_n", cpu_rst_n, 1'b0);
    chk_eq("start_err_clear", err, 1'b0);

    acc_t = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          drive_beat(rnd_beat());
          in_last = 1'b1;
          @(posedge clk); #1;
        end
      end
      drive_beat(beats[i]);
      in_valid = 1'b1;
      if (poke_start && i == 1) begin
        start = 1'b1;
        base_addr = 8'(base ^ 'h5A);
      end
      ok = 1'b0;
      tmo = 0;
      while (!ok && tmo < 16) begin
        rdy = in_ready;
        @(posedge clk);
        acc_t = int'($time);
        ok = rdy;
        #1;
        tmo++;
      end
      start = 1'b0;
      chk_eq("beat_accept", ok, 1'b1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_halt = 1'b0;
    chk_eq("ready_drop", in_ready, 1'b0);

    ok = 1'b0;
    tmo = 0;
    while (!ok && tmo < 8) begin
      @(negedge clk);
      ok = done;
      tmo++;
    end
    chk_eq("done_seen", ok, 1'b1);
    chk_eq("done_latency", 32'(int'($time) - acc_t), last_halt ? 32'd15 : 32'd25);
    chk_eq("release_cpu_rst_n", cpu_rst_n, 1'b1);
    chk_eq("start_pc", start_pc, 32'(base));
    chk_eq("err_flag", err, exp_err);
    chk_eq("release_busy", busy, 1'b0);
    @(negedge clk);
    chk_eq("done_pulse", done, 1'b0);
    chk_eq("idle_cpu_rst_n", cpu_rst_n, 1'b1);
    chk_eq("idle_mem_we", mem_we, 1'b0);

    chk_eq("n_writes", wa_q.size(), exp_a.size());
    for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++) begin
      chk_eq("wr_addr", wa_q[i], exp_a[i]);
      chk_eq("wr_data", wd_q[i], exp_d[i]);
      if (!gaps && i > 0) chk_eq("back_to_back", wt_q[i] - wt_q[i-1], 10);
    end
  endtask

  initial begin
    int lit1[4];
    int lit2[4];
    rst = 1'b1;
    start = 1'b0;
    base_addr = 8'h00;
    in_valid = 1'b0;
    drive_beat(mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", in_ready, 1'b0);
    chk_eq("rst_mem_we", mem_we, 1'b0);
    chk_eq("rst_mem_addr", mem_addr, 8'h00);
    chk_eq("rst_mem_wdata", mem_wdata, 16'h0000);
    chk_eq("rst_start_pc", start_pc, 8'h00);
    chk_eq("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // HALT-terminated program, back to back
    beats.delete();
    beats.push_back(mk(0, 0, 0, 0, 0, 78, 1'b0, 1'b0));
    beats.push_back(mk(1, 1, 0, 0, 2, 0, 1'b0, 1'b0));
    beats.push_back(mk(4, 2, 0, 1, 0, 0, 1'b0, 1'b0));
    beats.push_back(mk(0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
    run_session('h29, 1'b0, 1'b0);
    lit1 = '{'hD04E, 'hC030, 'hB041, 'hE000};
    for (int i = 0; i < 4 && i < wd_q.size(); i++) chk_eq("lit_prog1", wd_q[i], lit1[i]);

    // Program without HALT gets one appended
    beats.delete();
    beats.push_back(mk(0, 0, 1, 0, 0, 'hEF, 1'b0, 1'b0));
    beats.push_back(mk(2, 0, 0, 1, 0, 0, 1'b0, 1'b0));
    beats.push_back(mk(5, 2, 0, 0, 0, 0, 1'b0, 1'b1));
    run_session('h04, 1'b0, 1'b0);
    lit2 = '{'hD1EF, 'hA001, 'hB840, 'hE000};
    for (int i = 0; i < 4 && i < wd_q.size(); i++) chk_eq("lit_prog2", wd_q[i], lit2[i]);

    // Gapped valid, plus a start pulse that must be ignored mid-load
    beats.delete();
    for (int i = 0; i < 5; i++) beats.push_back(rnd_beat());
    beats[4].last = 1'b1;
    run_session('h80, 1'b1, 1'b1);

    // Address wrap
    beats.delete();
    for (int i = 0; i < 3; i++) beats.push_back(mk(0, 0, i, 0, 0, 'h11 * i, 1'b0, 1'b0));
    beats[2].last = 1'b1;
    run_session('hFE, 1'b0, 1'b0);

    // imm5 out of range: err set, word still written
    beats.delete();
    beats.push_back(mk(6, 1, 0, 0, 0, 'h10, 1'b0, 1'b1));
    run_session('h10, 1'b0, 1'b0);
    if (wd_q.size() > 0) chk_eq("lit_ldr", wd_q[0], 'h6030);

    // Reset mid-load
    start = 1'b1;
    base_addr = 8'h40;
    @(posedge clk); #1;
    start = 1'b0;
    drive_beat(mk(7, 1, 2, 0, 0, 'h40, 1'b0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive_beat(mk(0, 0, 3, 0, 0, 'h5C, 1'b0, 1'b0));
    @(posedge clk); #3;
    chk_eq("pre_rst_err", err, 1'b1);
    chk_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_in_ready", in_ready, 1'b0);
    chk_eq("mid_rst_mem_we", mem_we, 1'b0);
    chk_eq("mid_rst_mem_addr", mem_addr, 8'h00);
    chk_eq("mid_rst_mem_wdata", mem_wdata, 16'h0000);
    chk_eq("mid_rst_start_pc", start_pc, 8'h00);
    chk_eq("mid_rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk_eq("mid_rst_busy", busy, 1'b0);
    chk_eq("mid_rst_err", err, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk_eq("post_rst_in_ready", in_ready, 1'b0);

    // Randomized sessions
    for (int s = 0; s < 15; s++) begin
      int n;
      n = $urandom_range(1, 6);
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back(rnd_beat());
      beats[n-1].last = 1'b1;
      beats[n-1].halt = $urandom_range(0, 1);
      run_session($urandom_range(0, 255), $urandom_range(0, 1), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
